sample_ring_writer: RTL and testbench
=====================================

Name: sample_ring_writer

Overview:
- Upstream feeder for the 256x16 data memory (`datamem`). Its write-request outputs drive the memory's en/addr/in port directly.
- Accepts 16-bit input samples over a valid/ready handshake.
- Writes each sample into a circular region of data memory, `BASE..BASE+DEPTH-1`.
- Tracks buffer occupancy against a downstream consumer, and pulses a frame-done strobe every `FRAME` samples so the compute stage can start a block.

Parameters:
- AW, 8, address width; matches the data memory address bus.
- DW, 16, sample and data width.
- BASE, 8'h00, first address of the ring region.
- DEPTH, 16, ring size in words. Legal range 1..256, with BASE+DEPTH <= 256.
- FRAME, 4, samples per frame_done pulse. Legal range 1..DEPTH.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  leaves IDLE and enables acceptance.
- flush  in  1  synchronous clear of ring state; returns to IDLE.
- s_valid  in  1  input sample valid.
- s_data  in  DW  input sample.
- s_ready  out  1  block can accept a sample this cycle.
- consume  in  1  consumer frees one ring slot (1-cycle pulse per slot).
- mem_en  out  1  data memory write enable.
- mem_addr  out  AW  data memory address.
- mem_in  out  DW  data memory write data.
- wr_ptr  out  AW  address the next accepted sample will be written to.
- count  out  AW+1  number of occupied slots, 0..DEPTH.
- frame_done  out  1  one-cycle pulse when a frame completes.
- err  out  1  sticky flag; set by consume while count==0.

Behaviour:
- Synchronous reset (rst_n==0 at posedge):
  - State = IDLE; wr_ptr = BASE; mem_addr = BASE.
  - mem_en = 0; mem_in = 0; count = 0; frame counter = 0.
  - frame_done = 0; err = 0.
  - Reset mid-operation discards any pending write; mem_en is 0 in the following cycle.
- FSM has two states, IDLE and RUN:
  - IDLE -> RUN when start==1 and flush==0.
  - RUN -> IDLE on flush.
  - RUN holds otherwise; start has no effect in RUN.
- s_ready is combinational: 1 only when state==RUN, count != DEPTH and flush==0.
- An accept happens when s_valid && s_ready at a posedge.
  - Write latency is one cycle. On the accept edge, mem_en<=1, mem_addr<=wr_ptr and mem_in<=s_data. The write therefore lands in memory on the next edge.
  - mem_en<=0 on every edge without an accept. mem_addr and mem_in hold their last values.
- Pointer wrap: on an accept, wr_ptr <= BASE if wr_ptr==BASE+DEPTH-1, else wr_ptr+1.
- Count update, evaluated per edge:
  - accept only: +1.
  - valid consume only (count>0): -1.
  - accept and valid consume together: unchanged.
  - consume while count==0: count unchanged and err<=1.
  - consume in IDLE: obeys the same rules as in RUN.
- Full: when count==DEPTH, s_ready=0 and samples stall with s_data held. A consume in that same cycle does not raise s_ready until the next cycle.
- Frame counter runs 0..FRAME-1 and advances on each accept.
  - An accept while the counter is at FRAME-1 resets it to 0 and sets frame_done<=1 for exactly one cycle.
  - frame_done is 0 on all other edges.
- flush has priority below reset and above all else:
  - Clears wr_ptr to BASE, count to 0, frame counter to 0, mem_en to 0, frame_done to 0 and err to 0.
  - Moves state to IDLE.
  - No accept occurs in a flush cycle.
- count and wr_ptr are registered outputs. Both reflect an accept one cycle after the accept edge.

Test Plan:
1. Reset, then start, with BASE=8'h10, DEPTH=4, FRAME=2. Stream 16'h1111, 16'h2222 back-to-back -> mem_en high for 2 cycles at addr 8'h10 then 8'h11; frame_done pulses once, the cycle after the second accept; count=2; wr_ptr=8'h12.
2. Fill to full: 4 accepts with no consume -> count=4, s_ready=0. A 5th valid sample stalls with no mem_en. Pulse consume once -> s_ready=1 the next cycle; the 5th sample writes to addr 8'h10 (wrap), and count returns to 4.
3. Simultaneous accept and consume at count=2 -> count stays 2, wr_ptr advances by 1, and mem_en is asserted for 1 cycle.
4. Consume at count=0 -> err=1 and remains 1 through subsequent traffic; count stays 0. A flush clears err to 0.
5. Mid-stream flush after 3 accepts, while s_valid is high -> that cycle has no write; the next cycle shows wr_ptr=8'h10, count=0, s_ready=0 (IDLE). After start, the next sample writes to 8'h10, and frame_done fires after 2 more accepts.
6. rst_n low for one edge while mem_en==1 and count=3 -> the next cycle shows mem_en=0, count=0, wr_ptr=BASE, frame_done=0, err=0, s_ready=0; the memory contents at 8'h10..8'h13 read back unchanged afterwards.

Source files
------------

// File: rtl/sample_ring_writer.sv
// -----------------------------------------------------------------------------
// sample_ring_writer
//
// Upstream feeder for the 256x16 data memory. Input samples arrive over a
// valid/ready handshake and are written, one cycle later, into a circular
// region BASE..BASE+DEPTH-1 through the memory's en/addr/in port. Occupancy is
// tracked against a downstream consumer, and a one-cycle frame_done strobe is
// raised every FRAME accepted samples.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst_n       synchronous active-low reset
//   start       IDLE -> RUN (ignored while flush is high or already running)
//   flush       synchronous clear of ring state, back to IDLE
//   s_valid     input sample valid
//   s_data      input sample
//   s_ready     combinational: a sample can be accepted this cycle
//   consume     consumer frees one ring slot (one pulse per slot)
//   mem_en      registered memory write enable
//   mem_addr    registered memory write address
//   mem_in      registered memory write data
//   wr_ptr      address the next accepted sample will be written to
//   count       occupied slots, 0..DEPTH
//   frame_done  one-cycle pulse after the last sample of a frame is accepted
//   err         sticky: consume seen while the ring was empty
// -----------------------------------------------------------------------------
module sample_ring_writer #(
  parameter int unsigned   AW    = 8,
  parameter int unsigned   DW    = 16,
  parameter logic [AW-1:0] BASE  = 8'h00,
  parameter int unsigned   DEPTH = 16,
  parameter int unsigned   FRAME = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          flush,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  input  logic          consume,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  output logic [AW-1:0] wr_ptr,
  output logic [AW:0]   count,
  output logic          frame_done,
  output logic          err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(32'(BASE) + DEPTH - 32'd1);
  localparam logic [AW-1:0] FRAME_LAST = AW'(FRAME - 32'd1);
  localparam logic [AW-1:0] ONE_A      = AW'(1);
  localparam logic [AW:0]   ONE_C      = (AW+1)'(1);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] frame_q, frame_d;
  logic          mem_en_q, mem_en_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_in_q, mem_in_d;
  logic          frame_done_q, frame_done_d;
  logic          err_q, err_d;

  logic          s_ready_s;
  logic          accept_s;
  logic          consume_ok_s;

  // Handshake qualifiers; flush blocks acceptance in the same cycle.
  always_comb begin
    s_ready_s    = (state_q == ST_RUN) && (count_q != DEPTH_C) && !flush;
    accept_s     = s_valid && s_ready_s;
    // A consume only frees a slot when something is actually stored.
    consume_ok_s = consume && (count_q != '0);
  end

  // Next-state logic for FSM, pointer, occupancy, frame counter and write port.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    frame_d      = frame_q;
    mem_en_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_in_d     = mem_in_q;
    frame_done_d = 1'b0;
    err_d        = err_q;

    if (flush) begin
      state_d  = ST_IDLE;
      wr_ptr_d = BASE;
      count_d  = '0;
      frame_d  = '0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase

      if (accept_s) begin
        mem_en_d   = 1'b1;
        mem_addr_d = wr_ptr_q;
        mem_in_d   = s_data;
        if (wr_ptr_q == LAST_ADDR) begin
          wr_ptr_d = BASE;
        end else begin
          wr_ptr_d = wr_ptr_q + ONE_A;
        end
        if (frame_q == FRAME_LAST) begin
          frame_d      = '0;
          frame_done_d = 1'b1;
        end else begin
          frame_d      = frame_q + ONE_A;
          frame_done_d = 1'b0;
        end
      end else begin
        mem_en_d = 1'b0;
      end

      // Underflow is sticky until flush or reset; count is left alone.
      if (consume && !consume_ok_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end

      case ({accept_s, consume_ok_s})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= BASE;
      count_q      <= '0;
      frame_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= BASE;
      mem_in_q     <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      frame_q      <= frame_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_in_q     <= mem_in_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign s_ready    = s_ready_s;
  assign mem_en     = mem_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_in     = mem_in_q;
  assign wr_ptr     = wr_ptr_q;
  assign count      = count_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_sample_ring_writer.sv
// -----------------------------------------------------------------------------
// tb_sample_ring_writer
//
// Directed vector table (BASE=8'h10, DEPTH=4, FRAME=2), a hand-written
// memory-integrity sequence around reset, then randomized traffic compared
// against an integer-arithmetic reference model of the ring writer.
// A small 256x16 memory stands in for datamem.
// -----------------------------------------------------------------------------
module tb_sample_ring_writer;

  localparam int BASE_I  = 16;
  localparam int DEPTH_I = 4;
  localparam int FRAME_I = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        consume;
  logic        mem_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_in;
  logic [7:0]  wr_ptr;
  logic [8:0]  count;
  logic        frame_done;
  logic        err;

  sample_ring_writer #(
    .AW(8), .DW(16), .BASE(8'h10), .DEPTH(4), .FRAME(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .consume(consume), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_in(mem_in), .wr_ptr(wr_ptr), .count(count),
    .frame_done(frame_done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for datamem: writes land on the edge after mem_en is driven.
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en) mem[mem_addr] <= mem_in;
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Reference model: plain integers, ring offset arithmetic.
  int m_run, m_off, m_cnt, m_frame, m_err, m_en, m_addr, m_data, m_fd;

  task automatic model_step(input logic rn, st, fl, v, input logic [15:0] d, input logic cons);
    int acc;
    if (!rn) begin
      m_run = 0; m_off = 0; m_cnt = 0; m_frame = 0; m_err = 0;
      m_en = 0; m_addr = BASE_I; m_data = 0; m_fd = 0;
    end else if (fl) begin
      m_run = 0; m_off = 0; m_cnt = 0; m_frame = 0; m_err = 0;
      m_en = 0; m_fd = 0;
    end else begin
      acc  = (v && m_run != 0 && m_cnt != DEPTH_I) ? 1 : 0;
      m_en = acc;
      m_fd = 0;
      if (acc != 0) begin
        m_addr  = BASE_I + m_off;
        m_data  = int'(d);
        m_off   = (m_off + 1) % DEPTH_I;
        m_frame = m_frame + 1;
        if (m_frame == FRAME_I) begin
          m_frame = 0;
          m_fd    = 1;
        end
      end
      if (cons) begin
        if (m_cnt == 0) m_err = 1;
        else m_cnt = m_cnt - 1;
      end
      m_cnt = m_cnt + acc;
      if (m_run == 0 && st) m_run = 1;
    end
  endtask

  // Drive one cycle: inputs after the edge, s_ready sampled mid-cycle,
  // registered outputs sampled 1 time unit after the next rising edge.
  task automatic apply(input logic rn, st, fl, v, input logic [15:0] d, input logic cons,
                       output logic rdy_seen);
    rst_n = rn; start = st; flush = fl; s_valid = v; s_data = d; consume = cons;
    @(negedge clk);
    rdy_seen = s_ready;
    @(posedge clk);
    model_step(rn, st, fl, v, d, cons);
    #1;
  endtask

  typedef struct {
    logic rn, st, fl, v; logic [15:0] d; logic cons;
    logic rdy, en; logic [7:0] addr; logic [15:0] dat;
    logic [8:0] cnt; logic [7:0] ptr; logic fd, er;
  } vec_t;

  function automatic vec_t mk(input logic rn, st, fl, v, input logic [15:0] d, input logic cons,
                              input logic rdy, en, input logic [7:0] addr, input logic [15:0] dat,
                              input logic [8:0] cnt, input logic [7:0] ptr, input logic fd, er);
    vec_t r;
    r.rn = rn; r.st = st; r.fl = fl; r.v = v; r.d = d; r.cons = cons;
    r.rdy = rdy; r.en = en; r.addr = addr; r.dat = dat;
    r.cnt = cnt; r.ptr = ptr; r.fd = fd; r.er = er;
    return r;
  endfunction

  vec_t tbl[$];
  logic rdy_seen;
  logic exp_rdy;

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = 16'h0000; consume = 1'b0;

    //            rn    st    fl    v     data      cons  | rdy  en    addr   dat       cnt    ptr    fd    err
    // reset, start, two samples -> frame_done once
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,8'h10,16'h0000,9'd0,8'h10,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,8'h10,16'h0000,9'd0,8'h10,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'h1111,1'b0, 1'b1,1'b1,8'h10,16'h1111,9'd1,8'h11,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'h2222,1'b0, 1'b1,1'b1,8'h11,16'h2222,9'd2,8'h12,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,8'h11,16'h0000,9'd2,8'h12,1'b0,1'b0));
    // flush, restart, fill to full, stall, consume, wrap
    tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,16'h0000,1'b0, 1'b0,1'b0,8'h11,16'h0000,9'd0,8'h10,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,8'h11,16'h0000,9'd0,8'h10,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hA001,1'b0, 1'b1,1'b1,8'h10,16'hA001,9'd1,8'h11,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hA002,1'b0, 1'b1,1'b1,8'h11,16'hA002,9'd2,8'h12,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hA003,1'b0, 1'b1,1'b1,8'h12,16'hA003,9'd3,8'h13,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hA004,1'b0, 1'b1,1'b1,8'h13,16'hA004,9'd4,8'h10,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hA005,1'b0, 1'b0,1'b0,8'h13,16'h0000,9'd4,8'h10,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hA005,1'b1, 1'b0,1'b0,8'h13,16'h0000,9'd3,8'h10,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hA005,1'b0, 1'b1,1'b1,8'h10,16'hA005,9'd4,8'h11,1'b0,1'b0));
    // drain to 2, simultaneous accept + consume
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b0,1'b0,8'h10,16'h0000,9'd3,8'h11,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,8'h10,16'h0000,9'd2,8'h11,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hB001,1'b1, 1'b1,1'b1,8'h11,16'hB001,9'd2,8'h12,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,8'h11,16'h0000,9'd2,8'h12,1'b0,1'b0));
    // drain to 0, underflow -> sticky err, flush clears it
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,8'h11,16'h0000,9'd1,8'h12,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,8'h11,16'h0000,9'd0,8'h12,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,8'h11,16'h0000,9'd0,8'h12,1'b0,1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hC001,1'b0, 1'b1,1'b1,8'h12,16'hC001,9'd1,8'h13,1'b0,1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hC002,1'b0, 1'b1,1'b1,8'h13,16'hC002,9'd2,8'h10,1'b1,1'b1));
    tbl.push_back(mk(1'b1,1'b0,1'b1,1'b0,16'h0000,1'b0, 1'b0,1'b0,8'h13,16'h0000,9'd0,8'h10,1'b0,1'b0));
    // mid-stream flush with s_valid held high
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,8'h13,16'h0000,9'd0,8'h10,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hD001,1'b0, 1'b1,1'b1,8'h10,16'hD001,9'd1,8'h11,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hD002,1'b0, 1'b1,1'b1,8'h11,16'hD002,9'd2,8'h12,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hD003,1'b0, 1'b1,1'b1,8'h12,16'hD003,9'd3,8'h13,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b1,1'b1,16'hD004,1'b0, 1'b0,1'b0,8'h12,16'h0000,9'd0,8'h10,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hD004,1'b0, 1'b0,1'b0,8'h12,16'h0000,9'd0,8'h10,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b1,1'b0,1'b1,16'hD004,1'b0, 1'b0,1'b0,8'h12,16'h0000,9'd0,8'h10,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hD005,1'b0, 1'b1,1'b1,8'h10,16'hD005,9'd1,8'h11,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hD006,1'b0, 1'b1,1'b1,8'h11,16'hD006,9'd2,8'h12,1'b1,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,8'h11,16'h0000,9'd2,8'h12,1'b0,1'b0));
    // accept to count 3, then reset while mem_en is high
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hE001,1'b0, 1'b1,1'b1,8'h12,16'hE001,9'd3,8'h13,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,1'b1,16'hF00F,1'b0, 1'b1,1'b0,8'h10,16'h0000,9'd0,8'h10,1'b0,1'b0));
    tbl.push_back(mk(1'b1,1'b0,1'b0,1'b1,16'hF00F,1'b0, 1'b0,1'b0,8'h10,16'h0000,9'd0,8'h10,1'b0,1'b0));

    // Bring state out of X before the table.
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, rdy_seen);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, rdy_seen);

    foreach (tbl[i]) begin
      apply(tbl[i].rn, tbl[i].st, tbl[i].fl, tbl[i].v, tbl[i].d, tbl[i].cons, rdy_seen);
      chk($sformatf("v%0d_ready", i), 32'(rdy_seen), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(tbl[i].en));
      chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
      if (tbl[i].en) chk($sformatf("v%0d_mem_in", i), 32'(mem_in), 32'(tbl[i].dat));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_wr_ptr", i), 32'(wr_ptr), 32'(tbl[i].ptr));
      chk($sformatf("v%0d_frame_done", i), 32'(frame_done), 32'(tbl[i].fd));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].er));
    end

    // After the reset, idle cycles with s_valid high must not write memory.
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b1, 16'hF00F, 1'b0, rdy_seen);
      chk("post_reset_mem_en", 32'(mem_en), 32'd0);
    end
    chk("mem_10", 32'(mem[8'h10]), 32'h0000D005);
    chk("mem_11", 32'(mem[8'h11]), 32'h0000D006);
    chk("mem_12", 32'(mem[8'h12]), 32'h0000E001);
    chk("mem_13", 32'(mem[8'h13]), 32'h0000C002);

    // Consume while IDLE and empty still raises err; count stays 0.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, rdy_seen);
    chk("idle_underflow_err", 32'(err), 32'd1);
    chk("idle_underflow_count", 32'(count), 32'd0);
    chk("idle_underflow_ready", 32'(rdy_seen), 32'd0);

    // Randomized traffic against the reference model.
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, rdy_seen);
    for (int n = 0; n < 500; n++) begin
      logic rn, st, fl, v, cs;
      logic [15:0] d;
      rn = ($urandom_range(0, 59) != 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 29) == 0);
      v  = ($urandom_range(0, 9) < 7);
      cs = ($urandom_range(0, 9) < 4);
      d  = 16'($urandom);
      exp_rdy = (m_run != 0) && (m_cnt != DEPTH_I) && !fl;
      apply(rn, st, fl, v, d, cs, rdy_seen);
      chk("rnd_ready", 32'(rdy_seen), 32'(exp_rdy));
      chk("rnd_mem_en", 32'(mem_en), 32'(m_en));
      chk("rnd_mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("rnd_mem_in", 32'(mem_in), 32'(m_data));
      chk("rnd_count", 32'(count), 32'(m_cnt));
      chk("rnd_wr_ptr", 32'(wr_ptr), 32'(BASE_I + m_off));
      chk("rnd_frame_done", 32'(frame_done), 32'(m_fd));
      chk("rnd_err", 32'(err), 32'(m_err));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
